// File: rtl/conv_stream_engine.sv
// Streaming KxK ternary-weight convolution: a raster pixel stream in, one saturated
// (optionally ReLU-clamped) result vector per strided window position out.

module conv_feature_mac #(
   parameter int K  = 3,
   parameter int PW = 2,
   parameter int DW = 8
) (
   input  logic [K*K-1:0][PW-1:0] i_win,
   input  logic [K*K-1:0][1:0]    i_w,
   input  logic                   i_relu,
   output logic [DW-1:0]          o_res
);
   localparam int KK   = K * K;
   localparam int SUMW = PW + 2 + $clog2(KK);
   localparam int EW   = ((SUMW > DW) ? SUMW : DW) + 1;
   localparam logic signed [EW-1:0] SAT_MAX = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [EW-1:0] SAT_MIN = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic signed [SUMW-1:0] w_sum, w_p, w_k;
   logic signed [EW-1:0]   w_ext;

   always_comb begin
      w_sum = '0;
      w_p   = '0;
      w_k   = '0;
      for (int n = 0; n < KK; n++) begin
         w_p   = {{(SUMW-PW){i_win[n][PW-1]}}, i_win[n]};
         w_k   = {{(SUMW-2){i_w[n][1]}}, i_w[n]};
         w_sum = w_sum + w_p * w_k;
      end
   end

   assign w_ext = {{(EW-SUMW){w_sum[SUMW-1]}}, w_sum};

   always_comb begin
      o_res = w_ext[DW-1:0];
      if (i_relu && w_sum[SUMW-1])
         o_res = '0;
      else if (w_ext > SAT_MAX)
         o_res = SAT_MAX[DW-1:0];
      else if (w_ext < SAT_MIN)
         o_res = SAT_MIN[DW-1:0];
   end
endmodule

module conv_stream_engine #(
   parameter  int IMAGE_WIDTH  = 12,
   parameter  int IMAGE_HEIGHT = 12,
   parameter  int NUM_FEATURES = 2,
   parameter  int KERNEL_SIZE  = 3,
   parameter  int STRIDE       = 1,
   parameter  int PIXEL_WIDTH  = 2,
   parameter  int DATA_WIDTH   = 8,
   localparam int AW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_cnn,
   input  logic                                 feature_WrEn,
   input  logic [AW-1:0]                        feature_writeAddr,
   input  logic [2*KERNEL_SIZE*KERNEL_SIZE-1:0] weights_input,
   input  logic                                 relu_en,
   input  logic                                 pix_valid,
   input  logic [PIXEL_WIDTH-1:0]               pix_data,
   output logic                                 pix_ready,
   output logic                                 out_valid,
   output logic [NUM_FEATURES*DATA_WIDTH-1:0]   out_data,
   input  logic                                 out_ready,
   output logic                                 frame_done
);
   localparam int K  = KERNEL_SIZE;
   localparam int KK = K * K;
   localparam int W  = IMAGE_WIDTH;
   localparam int CW = $clog2(IMAGE_WIDTH);
   localparam int RW = $clog2(IMAGE_HEIGHT);
   localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   // K-1 full rows plus K-1 pixels of history; the incoming pixel is the newest tap
   localparam int HL = (K - 1) * W + K - 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
   localparam logic [CW-1:0] COL_K    = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_K    = RW'(K - 1);
   localparam logic [SW-1:0] SPH_LAST = SW'(STRIDE - 1);

   logic [CW-1:0]                                r_col;
   logic [RW-1:0]                                r_row;
   logic [SW-1:0]                                r_cph, r_rph;
   logic [HL-1:0][PIXEL_WIDTH-1:0]               r_hist;
   logic [NUM_FEATURES-1:0][KK-1:0][1:0]         r_w;
   logic                                         r_out_valid;
   logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0]      r_out_data;
   logic                                         r_frame_done;

   logic                                         w_accept, w_col_last, w_row_last;
   logic                                         w_win_done, w_wr_ok;
   logic [KK-1:0][PIXEL_WIDTH-1:0]               w_win;
   logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0]      w_res;

   assign pix_ready  = !r_out_valid || out_ready;
   assign w_accept   = pix_valid && pix_ready;
   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);
   assign w_win_done = w_accept && (r_row >= ROW_K) && (r_col >= COL_K) &&
                       (r_rph == '0) && (r_cph == '0);
   assign w_wr_ok    = !feature_WrEn && (r_row == '0) && (r_col == '0) &&
                       (32'(feature_writeAddr) < NUM_FEATURES);

   // Element (i,j) sits (K-1-i) rows and (K-1-j) pixels behind the incoming pixel
   for (genvar i = 0; i < K; i++) begin : g_wr
      for (genvar j = 0; j < K; j++) begin : g_wc
         localparam int D = (K - 1 - i) * W + (K - 1 - j);
         if (D == 0) begin : g_new
            assign w_win[i*K+j] = pix_data;
         end else begin : g_old
            assign w_win[i*K+j] = r_hist[D-1];
         end
      end
   end

   for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
      conv_feature_mac #(.K(K), .PW(PIXEL_WIDTH), .DW(DATA_WIDTH)) u_mac (
         .i_win  (w_win),
         .i_w    (r_w[f]),
         .i_relu (relu_en),
         .o_res  (w_res[f])
      );
   end

   always_ff @(posedge clk or negedge rst_cnn) begin
      if (!rst_cnn)
         r_w <= '0;
      else if (w_wr_ok)
         r_w[feature_writeAddr] <= weights_input;
   end

   always_ff @(posedge clk or negedge rst_cnn) begin
      if (!rst_cnn) begin
         r_col  <= '0;
         r_row  <= '0;
         r_cph  <= '0;
         r_rph  <= '0;
         r_hist <= '0;
      end else if (w_accept) begin
         r_hist <= {r_hist[HL-2:0], pix_data};
         if (w_col_last) begin
            r_col <= '0;
            r_cph <= '0;
            if (r_row >= ROW_K)
               r_rph <= (r_rph == SPH_LAST) ? '0 : r_rph + 1'b1;
            if (w_row_last) begin
               r_row <= '0;
               r_rph <= '0;
            end else begin
               r_row <= r_row + 1'b1;
            end
         end else begin
            r_col <= r_col + 1'b1;
            if (r_col >= COL_K)
               r_cph <= (r_cph == SPH_LAST) ? '0 : r_cph + 1'b1;
         end
      end
   end

   // A completing pixel wins over a drain, so back-to-back results keep valid high
   always_ff @(posedge clk or negedge rst_cnn) begin
      if (!rst_cnn) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_accept && w_col_last && w_row_last;
         if (w_win_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench: three engine instances (stride 1, stride 2, 4-bit output) on a 12x12 frame.

module tb_conv_stream_engine;
   logic        clk = 1'b0;
   logic        rst_cnn, wr_en, relu;
   logic [0:0]  wr_addr;
   logic [17:0] wts;
   logic [1:0]  pdata;
   logic [2:0]  pv, ordy, prdy, ov, fd;
   logic [15:0] od0, od1;
   logic [7:0]  od2;
   logic [15:0] odx [3];
   int          nassert = 0;
   int          nfail   = 0;

   always #5 clk = ~clk;

   assign odx[0] = od0;
   assign odx[1] = od1;
   assign odx[2] = {8'h00, od2};

   conv_stream_engine u0 (
      .clk(clk), .rst_cnn(rst_cnn), .feature_WrEn(wr_en), .feature_writeAddr(wr_addr),
      .weights_input(wts), .relu_en(relu), .pix_valid(pv[0]), .pix_data(pdata),
      .pix_ready(prdy[0]), .out_valid(ov[0]), .out_data(od0), .out_ready(ordy[0]),
      .frame_done(fd[0]));

   conv_stream_engine #(.STRIDE(2)) u1 (
      .clk(clk), .rst_cnn(rst_cnn), .feature_WrEn(wr_en), .feature_writeAddr(wr_addr),
      .weights_input(wts), .relu_en(relu), .pix_valid(pv[1]), .pix_data(pdata),
      .pix_ready(prdy[1]), .out_valid(ov[1]), .out_data(od1), .out_ready(ordy[1]),
      .frame_done(fd[1]));

   conv_stream_engine #(.DATA_WIDTH(4)) u2 (
      .clk(clk), .rst_cnn(rst_cnn), .feature_WrEn(wr_en), .feature_writeAddr(wr_addr),
      .weights_input(wts), .relu_en(relu), .pix_valid(pv[2]), .pix_data(pdata),
      .pix_ready(prdy[2]), .out_valid(ov[2]), .out_data(od2), .out_ready(ordy[2]),
      .frame_done(fd[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // kind 0: all +1, kind 1: all -1, kind 2: position-dependent pattern in -2..1
   function automatic int pixv(input int kind, input int r, input int c);
      case (kind)
         0:       return 1;
         1:       return -1;
         default: return ((r * 3 + c) % 4) - 2;
      endcase
   endfunction

   function automatic logic [17:0] kern_x();
      logic [17:0] w;
      w = '0;
      for (int k = 0; k < 9; k++) w[2*k +: 2] = (k % 2 == 0) ? 2'b01 : 2'b11;
      return w;
   endfunction

   task automatic load(input int addr, input logic [17:0] w);
      @(negedge clk);
      wr_addr = 1'(addr);
      wts     = w;
      wr_en   = 1'b0;
      @(negedge clk);
      wr_en   = 1'b1;
   endtask

   task automatic run_frame(input int d, input int kind, input int npix, input int drain,
                            input logic [15:0] expv, input int stride, input int stall_at,
                            input int midwr_at, input int nexp);
      int acc, last, res, post, cyc, fdn, r, c;
      bit stalled, wrdone, okpos;
      logic [15:0] expd, held;
      acc = 0; last = -1; res = 0; post = 0; cyc = 0; fdn = 0; stalled = 0; wrdone = 0;
      forever begin
         @(negedge clk);
         if (acc == npix && post >= drain) break;
         if (cyc > npix * 4 + 40) begin
            nassert++; nfail++;
            $error("FAIL timeout: dut %0d accepted %0d of %0d pixels", d, acc, npix);
            break;
         end
         cyc++;
         wr_en = 1'b1;
         if (midwr_at >= 0 && acc == midwr_at && !wrdone) begin
            wr_addr = 1'b0; wts = '1; wr_en = 1'b0; wrdone = 1;
         end
         pv[d]   = (acc < npix);
         pdata   = 2'(pixv(kind, acc / 12, acc % 12));
         ordy[d] = 1'b1;
         #1;
         if (ov[d] && res == stall_at && !stalled) begin
            stalled = 1; held = odx[d]; ordy[d] = 1'b0; wr_en = 1'b1;
            repeat (10) begin
               #1;
               chk("stall_ready", 32'(prdy[d]), 0);
               chk("stall_data",  32'(odx[d]), 32'(held));
               chk("stall_valid", 32'(ov[d]), 1);
               @(negedge clk);
            end
            ordy[d] = 1'b1;
            #1;
         end
         if (ov[d]) begin
            r = last / 12; c = last % 12;
            okpos = (r >= 2) && (c >= 2) && ((r - 2) % stride == 0) && ((c - 2) % stride == 0);
            expd  = (kind == 2) ? {8'(pixv(2, r, c - 1)), 8'(pixv(2, r - 2, c - 2))} : expv;
            chk("pos", 32'(okpos), 1);
            chk("data", 32'(odx[d]), 32'(expd));
            res++;
         end
         if (fd[d]) begin
            fdn++;
            chk("fd_last", 32'(last), 32'(npix - 1));
            chk("fd_valid", 32'(ov[d]), 32'(stride == 1));
         end
         if (pv[d] && prdy[d]) begin last = acc; acc++; end
         if (acc == npix) post++;
      end
      pv[d] = 1'b0;
      wr_en = 1'b1;
      if (nexp >= 0) begin
         chk("count", 32'(res), 32'(nexp));
         chk("fd_count", 32'(fdn), 1);
      end
   endtask

   initial begin
      rst_cnn = 1'b0; wr_en = 1'b1; wr_addr = '0; wts = '0; relu = 1'b0; pdata = '0;
      pv = '0; ordy = '1;
      #1;
      chk("rst_valid", 32'(ov[0]), 0);
      chk("rst_data",  32'(od0), 0);
      chk("rst_fd",    32'(fd[0]), 0);
      chk("rst_ready", 32'(prdy[0]), 1);
      @(negedge clk); @(negedge clk);
      rst_cnn = 1'b1;

      // X and all-ones kernels on an all-1 frame
      load(0, kern_x()); load(1, 18'h15555);
      run_frame(0, 0, 144, 3, 16'h0901, 1, -1, -1, 100);

      // single-tap kernels expose window addressing; backpressure mid-stream
      load(0, 18'h00001); load(1, 18'h04000);
      run_frame(0, 2, 144, 3, 16'h0000, 1, 7, -1, 100);

      // write mid-frame is ignored, idle write lands on the next frame
      load(0, kern_x()); load(1, 18'h15555);
      run_frame(0, 0, 144, 3, 16'h0901, 1, -1, 60, 100);
      load(0, 18'h15555);
      run_frame(0, 0, 144, 3, 16'h0909, 1, -1, -1, 100);

      // asynchronous reset with a result pending mid-frame
      load(0, kern_x()); load(1, 18'h15555);
      run_frame(0, 0, 48, 0, 16'h0901, 1, -1, -1, -1);
      ordy[0] = 1'b0;
      #1;
      chk("pre_rst_valid", 32'(ov[0]), 1);
      rst_cnn = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(ov[0]), 0);
      chk("mid_rst_data",  32'(od0), 0);
      chk("mid_rst_ready", 32'(prdy[0]), 1);
      @(negedge clk);
      rst_cnn = 1'b1; ordy[0] = 1'b1;
      run_frame(0, 0, 144, 3, 16'h0000, 1, -1, -1, 100);
      load(0, kern_x()); load(1, 18'h15555);
      run_frame(0, 0, 144, 3, 16'h0901, 1, -1, -1, 100);

      // stride 2
      run_frame(1, 0, 144, 3, 16'h0901, 2, -1, -1, 25);
      load(0, 18'h00001); load(1, 18'h04000);
      run_frame(1, 2, 144, 3, 16'h0000, 2, -1, -1, 25);

      // 4-bit output saturation and ReLU
      load(0, 18'h15555); load(1, 18'h15555);
      run_frame(2, 0, 144, 3, 16'h0077, 1, -1, -1, 100);
      run_frame(2, 1, 144, 3, 16'h0088, 1, -1, -1, 100);
      relu = 1'b1;
      run_frame(2, 1, 144, 3, 16'h0000, 1, -1, -1, 100);
      run_frame(2, 0, 144, 3, 16'h0077, 1, -1, -1, 100);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end
endmodule

// File: doc/conv_stream_engine.md
# conv_stream_engine

Streaming 2-D convolution engine that replaces the frame-buffered convolution stage of the CNN. Pixels arrive one per cycle in raster order over a valid/ready handshake. K-1 line buffers build a K×K window, and all NUM_FEATURES ternary-weight kernels are applied in parallel. The block emits one saturated, optionally ReLU-clamped result vector per window position, honouring a configurable stride, so the downstream pooling stage can also stream.

## Interface
- IMAGE_WIDTH, 12, pixels per row (≥ KERNEL_SIZE)
- IMAGE_HEIGHT, 12, rows per frame (≥ KERNEL_SIZE)
- NUM_FEATURES, 2, kernels evaluated in parallel
- KERNEL_SIZE, 3, window edge K (2..7)
- STRIDE, 1, window step in both axes (1..K)
- PIXEL_WIDTH, 2, signed pixel width
- DATA_WIDTH, 8, signed output width per feature
- clk  in  1  single clock, all state on rising edge
- rst_cnn  in  1  asynchronous, active-low reset
- feature_WrEn  in  1  active-low kernel write strobe
- feature_writeAddr  in  clog2(NUM_FEATURES)  kernel index to write
- weights_input  in  2·K·K  K·K signed 2-bit weights, element 0 in LSBs, row-major
- relu_en  in  1  1: clamp negative results to 0
- pix_valid  in  1  pixel offered
- pix_data  in  PIXEL_WIDTH  signed pixel
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- out_valid  out  1  result vector valid
- out_data  out  NUM_FEATURES·DATA_WIDTH  feature f in bits [f·DATA_WIDTH +: DATA_WIDTH]
- out_ready  in  1  downstream accepts result
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Weight RAM: NUM_FEATURES×K·K 2-bit entries, reset to 0.
  - On a rising edge with feature_WrEn=0, write weights_input to kernel feature_writeAddr, but only while idle (row=col=0).
  - Writes in mid-frame are ignored.
  - Out-of-range addresses are ignored.
- Counters: col (0..IMAGE_WIDTH-1) and row (0..IMAGE_HEIGHT-1) advance per accepted pixel and wrap to 0,0 after the last pixel. Frames are back-to-back with no gap cycle.
- Line buffers: K-1 rows × IMAGE_WIDTH × PIXEL_WIDTH, plus a K×K window shift register. Each accepted pixel shifts into the window and line buffers.
- A window is complete when the accepted pixel at (row,col) satisfies all of:
  - row ≥ K-1 and col ≥ K-1
  - (row-K+1) mod STRIDE = 0 and (col-K+1) mod STRIDE = 0

  Use stride phase counters, not dividers. Window element (i,j) is the pixel at (row-K+1+i, col-K+1+j).
- Arithmetic per feature:
  - sum = Σ w·p over the K·K terms, computed at full width PIXEL_WIDTH+2+clog2(K·K), signed.
  - If relu_en=1 and sum<0, the result is 0.
  - Otherwise the result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Output register: single stage. pix_ready = !out_valid || out_ready (combinational). A completing pixel loads out_data and sets out_valid; an output handshake without a new window clears out_valid.
- Output count per frame: ((H-K)/S+1)·((W-K)/S+1), integer division.

## Timing
- Reset values:
  - out_valid=0, out_data=0, frame_done=0
  - counters, window, line buffers and weights 0
  - pix_ready=1
- Latency: out_valid rises on the clock edge that accepts the window-completing pixel (visible the next cycle).
- Backpressure: while out_valid=1 and out_ready=0, pix_ready=0, out_data holds stable and no state advances.
- Simultaneous output handshake and window completion: the new result replaces the old one, and out_valid stays 1.
- frame_done is high for exactly one cycle, in the cycle after acceptance of pixel (H-1,W-1). It coincides with out_valid when that pixel completes a window.
- relu_en is sampled at the same edge as the result is registered.
- Asynchronous reset mid-frame clears counters, output and weights immediately. The next accepted pixel is (0,0).

## Test plan
- Load kernel 0 as X (1,-1,1,-1,1,-1,1,-1,1) and kernel 1 as all 1. Stream a 12×12 all-1 image. Expected:
  - exactly 100 results, each {f0=1, f1=9}
  - frame_done 1 cycle after pixel 144
- Same weights, STRIDE=2 → 25 results. Each result corresponds to pixel (row,col) with row,col ∈ {2,4,…,10}.
- DATA_WIDTH=4, all-1 image, kernel all 1 → f=7 (saturated). All -1 image with relu_en=0 → -8 (saturated from -9). With relu_en=1 → 0.
- Hold out_ready=0 for 10 cycles with out_valid=1. Expected: pix_ready=0, out_data unchanged, no pixel lost. After release, the total result count is still 100 and the values match the golden model.
- Assert feature_WrEn=0 mid-frame with new weights → results unchanged. The same write while idle takes effect for the next frame.
- Assert rst_cnn low after 50 pixels. Expected: out_valid=0 and weights 0. Reload weights and stream a full frame → 100 correct results.
